// File: rtl/johnson_ring_counter_param.sv
// Parametrised Johnson/ring shift counter with enable, up/down, parallel load,
// decoded phase index, wrap pulse and sticky illegal-state self-correction.
module johnson_ring_counter_param #(
  parameter int WIDTH = 4,
  parameter int MODE  = 0,
  localparam int PW   = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clr_err,
  output logic [WIDTH-1:0] count,
  output logic [PW-1:0]    phase,
  output logic             wrap,
  output logic             err
);

  localparam bit IS_RING = (MODE == 1);
  localparam int MOD     = IS_RING ? WIDTH : 2 * WIDTH;

  localparam logic [WIDTH-1:0] RESET_VALUE =
    IS_RING ? {{(WIDTH-1){1'b0}}, 1'b1} : {WIDTH{1'b0}};

  int   ones;
  int   transitions;
  int   set_index;
  int   phase_int;
  logic legal;

  logic [WIDTH-1:0] step_up;
  logic [WIDTH-1:0] step_down;

  // A legal Johnson word has at most one 0/1 boundary; a legal ring word has one hot bit.
  always_comb begin
    ones        = 0;
    transitions = 0;
    set_index   = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (count[i]) begin
        ones      = ones + 1;
        set_index = i;
      end
    end
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (count[i] != count[i+1]) begin
        transitions = transitions + 1;
      end
    end
    if (IS_RING) begin
      legal = (ones == 1);
    end else begin
      legal = (transitions <= 1);
    end
  end

  always_comb begin
    phase_int = 0;
    if (legal) begin
      if (IS_RING) begin
        phase_int = set_index;
      end else if (count == '0) begin
        phase_int = 0;
      end else if (count[0]) begin
        phase_int = ones;
      end else begin
        phase_int = 2 * WIDTH - ones;
      end
    end
  end

  assign phase = PW'(phase_int);

  always_comb begin
    if (IS_RING) begin
      step_up   = {count[WIDTH-2:0], count[WIDTH-1]};
      step_down = {count[0], count[WIDTH-1:1]};
    end else begin
      step_up   = {count[WIDTH-2:0], ~count[WIDTH-1]};
      step_down = {~count[0], count[WIDTH-1:1]};
    end
  end

  // Correction takes the whole edge: load and stepping are ignored while count is illegal.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= RESET_VALUE;
      wrap  <= 1'b0;
      err   <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (!legal) begin
        count <= RESET_VALUE;
        err   <= 1'b1;
      end else begin
        if (clr_err) begin
          err <= 1'b0;
        end
        if (load) begin
          count <= load_value;
        end else if (en) begin
          if (dir) begin
            count <= step_up;
            wrap  <= (phase_int == MOD - 1);
          end else begin
            count <= step_down;
            wrap  <= (phase_int == 0);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_johnson_ring_counter_param.sv
// Bench for johnson_ring_counter_param: a Johnson and a ring instance share one
// stimulus stream and are checked against vector tables and a phase-table model.
module tb_johnson_ring_counter_param;

  localparam int W  = 4;
  localparam int PW = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         en = 1'b0;
  logic         dir = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_value = '0;
  logic         clr_err = 1'b0;

  logic [W-1:0]  count_j, count_r;
  logic [PW-1:0] phase_j, phase_r;
  logic          wrap_j, wrap_r, err_j, err_r;

  int checks = 0;
  int passed = 0;

  logic [W-1:0] mcount [2];
  logic         mwrap  [2];
  logic         merr   [2];

  typedef struct {
    logic         rst, en, dir, load;
    logic [W-1:0] lv;
    logic         clr;
    logic [W-1:0] ec;
    logic [PW-1:0] ep;
    logic         ew, ee;
  } vec_t;

  vec_t tbl[$];

  johnson_ring_counter_param #(.WIDTH(W), .MODE(0)) dut_j (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load),
    .load_value(load_value), .clr_err(clr_err),
    .count(count_j), .phase(phase_j), .wrap(wrap_j), .err(err_j)
  );

  johnson_ring_counter_param #(.WIDTH(W), .MODE(1)) dut_r (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load),
    .load_value(load_value), .clr_err(clr_err),
    .count(count_r), .phase(phase_r), .wrap(wrap_r), .err(err_r)
  );

  always #5 clk = ~clk;

  function automatic int modulus(input int m);
    return (m == 1) ? W : 2 * W;
  endfunction

  // Count pattern of each phase, built directly from the sequence description.
  function automatic logic [W-1:0] pattern(input int m, input int k);
    int v;
    if (m == 1) v = 1 << k;
    else if (k <= W) v = (1 << k) - 1;
    else v = ((1 << W) - 1) & ~((1 << (k - W)) - 1);
    return W'(v);
  endfunction

  function automatic int find_phase(input int m, input logic [W-1:0] c);
    for (int k = 0; k < modulus(m); k++) begin
      if (pattern(m, k) == c) return k;
    end
    return -1;
  endfunction

  function automatic int exp_phase(input int m);
    int k;
    k = find_phase(m, mcount[m]);
    return (k < 0) ? 0 : k;
  endfunction

  task automatic model_step(input int m);
    int k;
    int md;
    k  = find_phase(m, mcount[m]);
    md = modulus(m);
    mwrap[m] = 1'b0;
    if (reset) begin
      mcount[m] = pattern(m, 0);
      merr[m]   = 1'b0;
    end else if (k < 0) begin
      mcount[m] = pattern(m, 0);
      merr[m]   = 1'b1;
    end else begin
      if (clr_err) merr[m] = 1'b0;
      if (load) begin
        mcount[m] = load_value;
      end else if (en) begin
        if (dir) begin
          mwrap[m]  = (k == md - 1);
          mcount[m] = pattern(m, (k + 1) % md);
        end else begin
          mwrap[m]  = (k == 0);
          mcount[m] = pattern(m, (k + md - 1) % md);
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic d,
                               input logic l, input logic [W-1:0] lv, input logic c);
    reset = r; en = e; dir = d; load = l; load_value = lv; clr_err = c;
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
  endtask

  task automatic checkDuts(input string tag);
    checkOutput({tag, "_j_count"}, 8'(count_j), 8'(mcount[0]));
    checkOutput({tag, "_j_phase"}, 8'(phase_j), 8'(exp_phase(0)));
    checkOutput({tag, "_j_wrap"},  8'(wrap_j),  8'(mwrap[0]));
    checkOutput({tag, "_j_err"},   8'(err_j),   8'(merr[0]));
    checkOutput({tag, "_r_count"}, 8'(count_r), 8'(mcount[1]));
    checkOutput({tag, "_r_phase"}, 8'(phase_r), 8'(exp_phase(1)));
    checkOutput({tag, "_r_wrap"},  8'(wrap_r),  8'(mwrap[1]));
    checkOutput({tag, "_r_err"},   8'(err_r),   8'(merr[1]));
  endtask

  task automatic addVec(input logic r, input logic e, input logic d, input logic l,
                        input logic [W-1:0] lv, input logic c, input logic [W-1:0] ec,
                        input logic [PW-1:0] ep, input logic ew, input logic ee);
    vec_t v;
    v.rst = r; v.en = e; v.dir = d; v.load = l; v.lv = lv; v.clr = c;
    v.ec = ec; v.ep = ep; v.ew = ew; v.ee = ee;
    tbl.push_back(v);
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      mcount[m] = '0; mwrap[m] = 1'b0; merr[m] = 1'b0;
    end

    // Johnson-instance vectors: rst en dir load lv clr | count phase wrap err
    addVec(1, 0, 1, 0, 4'h0, 0, 4'b0000, 0, 0, 0);
    for (int i = 0; i < 5; i++) addVec(0, 0, 1, 0, 4'h0, 0, 4'b0000, 0, 0, 0);
    addVec(0, 1, 1, 0, 4'h0, 0, 4'b0001, 1, 0, 0);
    addVec(0, 1, 1, 0, 4'h0, 0, 4'b0011, 2, 0, 0);
    addVec(0, 1, 1, 0, 4'h0, 0, 4'b0111, 3, 0, 0);
    addVec(0, 1, 1, 0, 4'h0, 0, 4'b1111, 4, 0, 0);
    addVec(0, 1, 1, 0, 4'h0, 0, 4'b1110, 5, 0, 0);
    addVec(0, 1, 1, 0, 4'h0, 0, 4'b1100, 6, 0, 0);
    addVec(0, 1, 1, 0, 4'h0, 0, 4'b1000, 7, 0, 0);
    addVec(0, 1, 1, 0, 4'h0, 0, 4'b0000, 0, 1, 0);
    addVec(0, 1, 0, 0, 4'h0, 0, 4'b1000, 7, 1, 0);
    addVec(0, 1, 0, 0, 4'h0, 0, 4'b1100, 6, 0, 0);
    addVec(0, 1, 1, 1, 4'b1110, 0, 4'b1110, 5, 0, 0);
    addVec(0, 1, 1, 0, 4'h0, 0, 4'b1100, 6, 0, 0);
    addVec(0, 0, 1, 1, 4'b0101, 0, 4'b0101, 0, 0, 0);
    addVec(0, 1, 1, 0, 4'h0, 0, 4'b0000, 0, 0, 1);
    addVec(0, 0, 1, 0, 4'h0, 1, 4'b0000, 0, 0, 0);
    addVec(0, 1, 1, 0, 4'h0, 0, 4'b0001, 1, 0, 0);
    addVec(0, 1, 1, 0, 4'h0, 0, 4'b0011, 2, 0, 0);
    addVec(1, 1, 1, 0, 4'h0, 0, 4'b0000, 0, 0, 0);
    addVec(0, 0, 1, 1, 4'b1010, 0, 4'b1010, 0, 0, 0);
    addVec(0, 1, 1, 0, 4'h0, 1, 4'b0000, 0, 0, 1);
    addVec(0, 0, 1, 0, 4'h0, 1, 4'b0000, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].rst, tbl[i].en, tbl[i].dir, tbl[i].load, tbl[i].lv, tbl[i].clr);
      checkOutput($sformatf("tbl%0d_count", i), 8'(count_j), 8'(tbl[i].ec));
      checkOutput($sformatf("tbl%0d_phase", i), 8'(phase_j), 8'(tbl[i].ep));
      checkOutput($sformatf("tbl%0d_wrap", i),  8'(wrap_j),  8'(tbl[i].ew));
      checkOutput($sformatf("tbl%0d_err", i),   8'(err_j),   8'(tbl[i].ee));
      checkDuts($sformatf("tbl%0d", i));
    end

    // Ring corner sequence: reset value, full forward lap with wrap, then wrap going down.
    applyStimulus(1, 0, 1, 0, 4'h0, 0);
    checkOutput("ring_reset_count", 8'(count_r), 8'b0001);
    checkOutput("ring_reset_phase", 8'(phase_r), 8'd0);
    begin
      logic [W-1:0] ring_seq [4];
      ring_seq[0] = 4'b0010; ring_seq[1] = 4'b0100; ring_seq[2] = 4'b1000; ring_seq[3] = 4'b0001;
      for (int i = 0; i < 4; i++) begin
        applyStimulus(0, 1, 1, 0, 4'h0, 0);
        checkOutput($sformatf("ring_up%0d_count", i), 8'(count_r), 8'(ring_seq[i]));
        checkOutput($sformatf("ring_up%0d_phase", i), 8'(phase_r), 8'((i + 1) % 4));
        checkOutput($sformatf("ring_up%0d_wrap", i),  8'(wrap_r),  8'(i == 3));
        checkDuts($sformatf("ring_up%0d", i));
      end
    end
    applyStimulus(0, 1, 0, 0, 4'h0, 0);
    checkOutput("ring_down_count", 8'(count_r), 8'b1000);
    checkOutput("ring_down_phase", 8'(phase_r), 8'd3);
    checkOutput("ring_down_wrap",  8'(wrap_r),  8'd1);
    applyStimulus(0, 1, 0, 0, 4'h0, 0);
    checkOutput("ring_down2_wrap", 8'(wrap_r), 8'd0);
    checkDuts("ring_down2");

    for (int i = 0; i < 400; i++) begin
      logic         r, e, d, l, c;
      logic [W-1:0] lv;
      r  = ($urandom_range(0, 31) == 0);
      l  = ($urandom_range(0, 7) == 0);
      e  = ($urandom_range(0, 3) != 0);
      d  = 1'($urandom_range(0, 1));
      c  = ($urandom_range(0, 5) == 0);
      lv = W'($urandom);
      applyStimulus(r, e, d, l, lv, c);
      checkDuts($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
